// File: rtl/mem_byte_bridge.sv
// mem_byte_bridge
// Turns one 32-bit core load/store (byte, half or word) into a sequence of
// little-endian byte beats on a valid/ready memory bus. Loads are assembled
// and sign/zero-extended. Misaligned or illegal requests fault without any
// bus activity. A per-beat stall counter aborts a hung bus with a fault.

module mem_byte_bridge #(
    parameter int TIMEOUT_CYCLES = 255,  // stalled cycles allowed per beat, 0 = never abort
    parameter int TIMEOUT_WIDTH  = 8     // stall counter width, must hold TIMEOUT_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_read_data,
    output logic        o_fault,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // The abort fires on the stalled edge where the counter would reach
    // TIMEOUT_CYCLES, i.e. when it already holds TIMEOUT_CYCLES-1.
    localparam bit                       TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE  = TIMEOUT_WIDTH'(1);

    state_t                    r_state;
    state_t                    w_state_next;

    // Captured request
    logic [3:0]                r_op;
    logic [31:0]               r_addr;
    logic [31:0]               r_wdata;
    logic [1:0]                r_last;      // index of the final beat (N-1)

    // Beat progress
    logic [1:0]                r_idx;
    logic [TIMEOUT_WIDTH-1:0]  r_stall;
    logic [31:0]               r_asm;       // load bytes gathered so far

    // Held results
    logic [31:0]               r_read_data;
    logic                      r_fault;

    // Decode of the incoming request
    logic                      w_illegal;
    logic [1:0]                w_last;

    // Beat handshake qualifiers (bus_valid is implied by being in ACCESS)
    logic                      w_accept;
    logic                      w_stall;
    logic                      w_final;
    logic                      w_timeout;

    // Load assembly including the byte arriving this cycle, and its extension
    logic [31:0]               w_asm;
    logic [31:0]               w_ext;
    logic [7:0]                w_wbyte;

    assign w_accept  = (r_state == S_ACCESS) && i_bus_ready;
    assign w_stall   = (r_state == S_ACCESS) && !i_bus_ready;
    assign w_final   = w_accept && (r_idx == r_last);
    assign w_timeout = TO_EN && w_stall && (r_stall == TO_LAST);

    // Decode beat count and legality straight from the request inputs
    always_comb begin
        w_illegal = 1'b0;
        w_last    = 2'd0;
        case (i_op[1:0])
            2'b00: w_last = 2'd0;
            2'b01: begin
                w_last    = 2'd1;
                w_illegal = i_addr[0];
            end
            2'b10: begin
                w_last    = 2'd3;
                w_illegal = |i_addr[1:0];
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Merge the current read byte into the assembly at the beat's lane
    always_comb begin
        w_asm = r_asm;
        w_asm[{r_idx, 3'b000} +: 8] = i_bus_rdata;
    end

    // Size-dependent extension of the fully assembled load
    always_comb begin
        w_ext = w_asm;
        case (r_op[1:0])
            2'b00:   w_ext = {{24{~r_op[2] & w_asm[7]}},  w_asm[7:0]};
            2'b01:   w_ext = {{16{~r_op[2] & w_asm[15]}}, w_asm[15:0]};
            default: w_ext = w_asm;
        endcase
    end

    assign w_wbyte = r_wdata[{r_idx, 3'b000} +: 8];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: illegal requests skip ACCESS, timeouts and last beats end it
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = w_illegal ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_final || w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control outputs decoded from the registered state
    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_bus_valid = 1'b0;
        o_bus_we    = 1'b0;
        case (r_state)
            S_ACCESS: begin
                o_busy      = 1'b1;
                o_bus_valid = 1'b1;
                o_bus_we    = r_op[3];
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Beat address and data only move when the captured request or index
    // moves, so they stay stable through stalls.
    assign o_bus_addr  = r_addr + {30'd0, r_idx};
    assign o_bus_wdata = w_wbyte;
    assign o_read_data = r_read_data;
    assign o_fault     = r_fault;

    // Request capture, beat stepping, stall counting and result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op        <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_last      <= 2'd0;
            r_idx       <= 2'd0;
            r_stall     <= '0;
            r_asm       <= 32'd0;
            r_read_data <= 32'd0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op        <= i_op;
                        r_addr      <= i_addr;
                        r_wdata     <= i_write_data;
                        r_last      <= w_last;
                        r_idx       <= 2'd0;
                        r_stall     <= '0;
                        r_asm       <= 32'd0;
                        r_read_data <= 32'd0;
                        r_fault     <= w_illegal;
                    end
                end
                S_ACCESS: begin
                    if (w_accept) begin
                        r_stall <= '0;
                        if (!r_op[3]) begin
                            r_asm <= w_asm;
                        end
                        if (w_final) begin
                            if (!r_op[3]) begin
                                r_read_data <= w_ext;
                            end
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else if (w_timeout) begin
                        r_stall <= '0;
                        r_fault <= 1'b1;
                    end else if (TO_EN) begin
                        r_stall <= r_stall + TO_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_byte_bridge.md
Name: mem_byte_bridge

Overview:
Sits directly downstream of the core's memory port. Converts one 32-bit load/store request (byte, half or word) into a sequence of byte-wide beats on an external valid/ready memory bus. Bytes are little-endian. Loads are assembled and sign/zero-extended; misaligned or illegal requests are faulted without bus activity. A per-beat timeout aborts a hung bus and reports a fault.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive stalled cycles per beat before abort; 0 disables timeout
TIMEOUT_WIDTH, 8, width of the stall counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only in IDLE
op  input  4  [3]=write, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word, 11 illegal)
addr  input  32  byte address of request
write_data  input  32  store data; low bytes used per size
busy  output  1  high in ACCESS and DONE
done  output  1  one-cycle completion pulse
read_data  output  32  extended load result; held until next accepted start
fault  output  1  misalign/illegal/timeout; held until next accepted start
bus_valid  output  1  beat request
bus_ready  input  1  beat accepted when bus_valid & bus_ready at rising edge
bus_we  output  1  beat is a write
bus_addr  output  32  beat byte address
bus_wdata  output  8  beat write byte
bus_rdata  input  8  beat read byte, valid in the accepting cycle

Behaviour:
- Reset: state IDLE; busy, done, fault, bus_valid, bus_we = 0; read_data, bus_addr, bus_wdata = 0; beat index and stall counter = 0.
- Reset mid-operation aborts immediately: bus_valid is low in the cycle after the reset edge. No done pulse is generated. Bytes already written are not rolled back.
- States are IDLE, ACCESS and DONE.
- IDLE:
  - On start=1, capture op, addr and write_data. Clear fault and read_data.
  - Beat count N = 1, 2 or 4 from size.
  - Illegal if size=11, half with addr[0]=1, or word with addr[1:0]!=0. An illegal request goes to DONE with fault=1; bus_valid never asserts.
  - A legal request goes to ACCESS with index 0.
- start outside IDLE is ignored with no effect.
- ACCESS:
  - bus_valid=1, bus_we=op[3], bus_addr=captured addr+index (32-bit wrap), bus_wdata=write_data byte[index].
  - bus_valid stays high across consecutive beats; outputs change only after an accepted beat.
  - On an accepted beat:
    - For a read, store bus_rdata into assembly byte[index].
    - Clear the stall counter.
    - If index=N-1, go to DONE; otherwise increment index.
  - On a stalled cycle (valid & ~ready) with TIMEOUT_CYCLES!=0, increment the stall counter. The edge on which it would reach TIMEOUT_CYCLES goes to DONE with fault=1. bus_valid is therefore high for exactly TIMEOUT_CYCLES cycles of a hung beat.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, then IDLE. The edge entering DONE from a successful read loads read_data.
  - Byte extension: bit 7 extended unless op[2]=1 (then zero-extended).
  - Half extension: bit 15 extended unless op[2]=1.
  - Word: no extension.
  - Writes and faults leave read_data=0.
- Latency: a start accepted at edge t with zero-wait ready gives bus_valid in cycles t+1..t+N and done in cycle t+N+1. A fault on decode gives done in cycle t+1. Each stall cycle adds one.
- A new start is accepted in the IDLE cycle after DONE, at the earliest.

Test Plan:
- LW addr=0x100, ready=1, rdata 0x11,0x22,0x33,0x44 -> bus_addr 0x100..0x103; read_data=0x44332211; done at t+5; fault=0.
- LB addr=0x203, rdata=0x80 -> read_data=0xFFFFFF80. LBU (op=4'b0100) same -> 0x00000080. LH addr=0x10, rdata 0x34,0x92 -> 0xFFFF9234.
- SH addr=0x2, write_data=0xDEADBEEF, ready toggling 0,1,0,1 -> beats (0x2,0xEF),(0x3,0xBE) with bus_we=1; addr/wdata stable through stalls; done at t+5.
- Misaligned/illegal requests: LH addr=0x1, SW addr=0x6, or size=11 -> bus_valid stays 0; done and fault at t+1; read_data=0. Next legal start clears fault.
- TIMEOUT_CYCLES=4, LW with ready held 0 -> bus_valid high t+1..t+4; done+fault at t+5. With TIMEOUT_CYCLES=0, ready held low for 1000 cycles -> never faults and completes once ready rises.
- Reset asserted during beat 2 of an SW -> next cycle: bus_valid=0, busy=0, no done. start pulsed while busy -> ignored with captured request unchanged.
